load_dispatch8: RTL and testbench

//  Upstream feeder for the 1-bit 8-way demultiplexer in an 8-word register bank.
//  - Accepts write requests (3-bit word address + data) on a valid/ready port and buffers them in a FIFO.
//  - Issues at most one registered load strobe per cycle: loadOut feeds the demux 'in', selOut feeds 'sel'.
//  - Also runs a bank-clear sequence that writes 0 to words 0..7 in order.

---
 rtl/load_dispatch8.sv | 129 ++++++++++++
 tb/tb_load_dispatch8.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/load_dispatch8.sv
// load_dispatch8: buffers word-write requests in a FIFO and issues one registered
// load strobe per cycle (loadOut/selOut/dataOut) to an 8-way demux register bank.
// A bank-clear drains the FIFO, then sweeps zeros into words 0..7 in order.
module load_dispatch8 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       inValid,
  output logic                       inReady,
  input  logic [2:0]                 inAddr,
  input  logic [WIDTH-1:0]           inData,
  input  logic                       hold,
  input  logic                       clrReq,
  output logic                       clrBusy,
  output logic                       loadOut,
  output logic [2:0]                 selOut,
  output logic [WIDTH-1:0]           dataOut,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [2:0]       addr;
    logic [WIDTH-1:0] data;
  } req_t;

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;

  req_t          mem [DEPTH];
  logic [PW-1:0] head, tail;
  state_t        state, state_nxt;
  logic [2:0]    sweep, sweep_nxt;
  logic          push, pop, sweep_wr;
  logic [LW-1:0] level_nxt;
  req_t          head_req;

  // Handshake is gated by reset so no request is taken while rst_n is low;
  // no bypass when full, even if an entry leaves this cycle.
  assign inReady  = rst_n && (state == RUN) && (level < LW'(DEPTH));
  assign push     = inValid && inReady;
  assign pop      = ((state == RUN) || (state == DRAIN)) && !hold && (level != '0);
  assign sweep_wr = (state == CLEAR) && !hold;
  assign clrBusy  = (state != RUN);
  assign head_req = mem[head];

  // Next occupancy; used by DRAIN to leave on the edge the FIFO empties.
  always_comb begin
    level_nxt = level + LW'(push) - LW'(pop);
  end

  // Next-state logic: RUN -> DRAIN/CLEAR on clrReq, DRAIN -> CLEAR when empty,
  // CLEAR walks sweep 0..7 (paused by hold) then returns to RUN.
  always_comb begin
    state_nxt = state;
    sweep_nxt = sweep;
    case (state)
      RUN: begin
        if (clrReq) begin
          if (level != '0) begin
            state_nxt = DRAIN;
          end else begin
            state_nxt = CLEAR;
            sweep_nxt = '0;
          end
        end
      end
      DRAIN: begin
        if (level_nxt == '0) begin
          state_nxt = CLEAR;
          sweep_nxt = '0;
        end
      end
      CLEAR: begin
        if (!hold) begin
          sweep_nxt = sweep + 3'd1;
          if (sweep == 3'd7) state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // FIFO storage; contents need no reset because pointers/level define validity.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{addr: inAddr, data: inData};
  end

  // FSM, sweep counter, FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      sweep <= '0;
      head  <= '0;
      tail  <= '0;
      level <= '0;
    end else begin
      state <= state_nxt;
      sweep <= sweep_nxt;
      level <= level_nxt;
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
    end
  end

  // Registered strobe: FIFO head on a pop, zero write during the sweep, else idle
  // with select/data holding their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loadOut <= 1'b0;
      selOut  <= '0;
      dataOut <= '0;
    end else if (pop) begin
      loadOut <= 1'b1;
      selOut  <= head_req.addr;
      dataOut <= head_req.data;
    end else if (sweep_wr) begin
      loadOut <= 1'b1;
      selOut  <= sweep;
      dataOut <= '0;
    end else begin
      loadOut <= 1'b0;
    end
  end

endmodule

// File: tb/tb_load_dispatch8.sv
// Directed bench for load_dispatch8 (WIDTH=16, DEPTH=4).
module tb_load_dispatch8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid;
  logic        inReady;
  logic [2:0]  inAddr;
  logic [15:0] inData;
  logic        hold;
  logic        clrReq;
  logic        clrBusy;
  logic        loadOut;
  logic [2:0]  selOut;
  logic [15:0] dataOut;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;

  load_dispatch8 #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
    .inAddr(inAddr), .inData(inData), .hold(hold), .clrReq(clrReq),
    .clrBusy(clrBusy), .loadOut(loadOut), .selOut(selOut), .dataOut(dataOut),
    .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock edge, then settle 1 time unit
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input string tag, input logic [2:0] sel, input logic [15:0] dat);
    chk({tag, ".load"}, 32'(loadOut), 32'd1);
    chk({tag, ".sel"},  32'(selOut),  32'(sel));
    chk({tag, ".data"}, 32'(dataOut), 32'(dat));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; inValid = 1'b0; inAddr = '0; inData = '0;
    hold = 1'b0; clrReq = 1'b0;

    // 1. reset
    repeat (3) step();
    chk("rst.load", 32'(loadOut), 0);
    chk("rst.sel", 32'(selOut), 0);
    chk("rst.data", 32'(dataOut), 0);
    chk("rst.busy", 32'(clrBusy), 0);
    chk("rst.level", 32'(level), 0);
    chk("rst.ready", 32'(inReady), 0);
    rst_n = 1'b1;
    #1;
    chk("rel.ready", 32'(inReady), 1);
    chk("rel.level", 32'(level), 0);

    // 2. single write
    inValid = 1'b1; inAddr = 3'd5; inData = 16'h1234;
    step();
    inValid = 1'b0;
    chk("single.k.load", 32'(loadOut), 0);
    chk("single.k.level", 32'(level), 1);
    step();
    strobe("single.k1", 3'd5, 16'h1234);
    chk("single.k1.level", 32'(level), 0);
    step();
    chk("single.k2.load", 32'(loadOut), 0);
    chk("single.k2.sel", 32'(selOut), 5);
    chk("single.k2.data", 32'(dataOut), 32'h1234);

    // 3. fill with hold=1, fifth request refused
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      inValid = 1'b1; inAddr = 3'(i); inData = 16'hA000 + 16'(i);
      step();
      chk("fill.level", 32'(level), (i < 4) ? i + 1 : 4);
      chk("fill.load", 32'(loadOut), 0);
    end
    chk("full.ready", 32'(inReady), 0);
    inValid = 1'b0; hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      strobe("drain4", 3'(i), 16'hA000 + 16'(i));
      chk("drain4.level", 32'(level), 3 - i);
      chk("drain4.ready", 32'(inReady), 1);
    end
    step();
    chk("drain4.idle", 32'(loadOut), 0);

    // 4. streaming 20 requests
    for (int i = 0; i < 20; i++) begin
      inValid = 1'b1; inAddr = 3'(i % 8); inData = 16'hB000 + 16'(i);
      step();
      chk("stream.level", 32'(level), 1);
      if (i > 0) strobe("stream", 3'((i - 1) % 8), 16'hB000 + 16'(i - 1));
      else chk("stream.first", 32'(loadOut), 0);
    end
    inValid = 1'b0;
    step();
    strobe("stream.last", 3'd3, 16'hB013);
    chk("stream.endlevel", 32'(level), 0);

    // 5. clear with two entries queued
    hold = 1'b1;
    inValid = 1'b1; inAddr = 3'd3; inData = 16'hC003;
    step();
    inAddr = 3'd6; inData = 16'hC006;
    step();
    inValid = 1'b0;
    chk("clr.q.level", 32'(level), 2);
    clrReq = 1'b1;
    step();
    clrReq = 1'b0; hold = 1'b0;
    chk("clr.drain.busy", 32'(clrBusy), 1);
    chk("clr.drain.ready", 32'(inReady), 0);
    chk("clr.drain.level", 32'(level), 2);
    chk("clr.drain.load", 32'(loadOut), 0);
    step();
    strobe("clr.q0", 3'd3, 16'hC003);
    chk("clr.q0.busy", 32'(clrBusy), 1);
    step();
    strobe("clr.q1", 3'd6, 16'hC006);
    chk("clr.q1.busy", 32'(clrBusy), 1);
    chk("clr.q1.level", 32'(level), 0);
    for (int s = 0; s < 8; s++) begin
      step();
      strobe("clr.sweep", 3'(s), 16'h0000);
      chk("clr.sweep.busy", 32'(clrBusy), (s == 7) ? 0 : 1);
      chk("clr.sweep.ready", 32'(inReady), (s == 7) ? 1 : 0);
    end
    step();
    chk("clr.done.load", 32'(loadOut), 0);

    // 6. clear from empty, hold at sweep=3, then async reset
    clrReq = 1'b1;
    step();
    clrReq = 1'b0;
    chk("abort.busy", 32'(clrBusy), 1);
    chk("abort.start.load", 32'(loadOut), 0);
    for (int s = 0; s < 3; s++) begin
      step();
      strobe("abort.sweep", 3'(s), 16'h0000);
    end
    hold = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.load", 32'(loadOut), 0);
    chk("abort.busy0", 32'(clrBusy), 0);
    chk("abort.sel", 32'(selOut), 0);
    chk("abort.ready", 32'(inReady), 0);
    chk("abort.level", 32'(level), 0);
    step();
    rst_n = 1'b1; hold = 1'b0;
    inValid = 1'b1; inAddr = 3'd7; inData = 16'hDEAD;
    step();
    inValid = 1'b0;
    chk("post.level", 32'(level), 1);
    chk("post.load0", 32'(loadOut), 0);
    step();
    strobe("post", 3'd7, 16'hDEAD);
    chk("post.busy", 32'(clrBusy), 0);
    step();
    chk("post.idle", 32'(loadOut), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
